mem_port_arbiter: RTL

Sequential arbiter sharing one single-port unified instruction/data memory between the pipeline's fetch stage and its memory stage. Each request is granted, the memory port is driven for a fixed number of cycles, read data is captured, and the winner gets a one-cycle `ready` pulse. While a port's `ready` is low, the pipeline stalls that stage. It sits between the core's fetch and memory stages and the memory, replacing separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port unified memory between the fetch stage (if_*) and
// the memory stage (d_*). A request is granted in IDLE, the memory port is
// held for MEM_LAT cycles (BUSY), read data is captured on the last BUSY
// cycle, and the winner gets a one-cycle ready pulse (RESP).
//
// Handshake: a requester raises req with address/data and holds them stable
// until its ready pulse. ready is high for exactly one cycle per granted
// access. req still high in the cycle after ready counts as a new request.
// Dropping req after the grant does not abort the access.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_req/if_addr      fetch request and address
//   if_rdata/if_ready   registered fetch data, completion pulse
//   d_req/d_we/d_addr/d_wdata   data request (d_we=1 store, 0 load)
//   d_rdata/d_ready     registered load data, completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   fsm_state           debug view of the FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking.
// Without it, data always wins a tie over fetch.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic       gnt_d;    // 1: current access belongs to the data port
   logic       lat_we;   // latched store flag, only set for a data grant
   logic       any_req;
   logic       pick_d;   // data port wins this arbitration

   assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   // rr_d = 1 means data wins the next tie; flips to the loser on each grant.
   logic rr_d;

   assign pick_d = d_req & (~if_req | rr_d);

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_d <= 1'b1;
      end else if (state == S_IDLE && any_req) begin
         rr_d <= ~pick_d;
      end
   end
`else
   assign pick_d = d_req;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_BUSY;
         S_BUSY:  if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state and the latched grant
   always_comb begin
      mem_en    = (state == S_BUSY);
      mem_we    = (state == S_BUSY) & lat_we;
      if_ready  = (state == S_RESP) & ~gnt_d;
      d_ready   = (state == S_RESP) & gnt_d;
      fsm_state = state;
   end

   // Grant latch, memory-port registers, counter and read-data capture.
   // mem_addr/mem_wdata are the latch itself, so they hold between accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= 4'd0;
         gnt_d     <= 1'b0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  cnt    <= 4'(MEM_LAT - 1);
                  gnt_d  <= pick_d;
                  lat_we <= pick_d & d_we;
                  if (pick_d) begin
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_addr  <= if_addr;
                  end
               end
            end
            S_BUSY: begin
               if (cnt == 4'd0) begin
                  if (!gnt_d) begin
                     if_rdata <= mem_rdata;
                  end else if (!lat_we) begin
                     d_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
